// File: rtl/ex_mem_pipe_pkg.sv
// Shared pipeline definitions: NOP/bubble encodings, default widths and the
// per-edge action decode used by the EX/MEM register.
package ex_mem_pipe_pkg;

   localparam logic        RstEnable    = 1'b1;
   localparam logic        RstDisable   = 1'b0;
   localparam logic        WriteEnable  = 1'b1;
   localparam logic        WriteDisable = 1'b0;
   localparam logic [31:0] ZeroWord     = 32'h0000_0000;
   localparam logic [4:0]  NOPRegAddr   = 5'b00000;
   localparam logic [7:0]  EXE_NOP_OP   = 8'b0000_0000;

   localparam int DEF_DATA_W     = 32;
   localparam int DEF_REG_ADDR_W = 5;
   localparam int DEF_ALUOP_W    = 8;
   localparam int DEF_CNT_W      = 2;
   localparam int DEF_PERF_W     = 16;

   typedef enum logic [2:0] {
      ACT_RESET,
      ACT_FLUSH,
      ACT_HOLD,
      ACT_BUBBLE,
      ACT_ADVANCE
   } pipe_act_e;

   // Priority chain: reset, flush, MEM stall, EX stall, advance.
   // A MEM stall without an EX stall is illegal and falls into HOLD.
   function automatic pipe_act_e decode_act(input logic rst,
                                            input logic flush,
                                            input logic stall_mem,
                                            input logic stall_ex);
      pipe_act_e act;
      if (rst == RstEnable)  act = ACT_RESET;
      else if (flush)        act = ACT_FLUSH;
      else if (stall_mem)    act = ACT_HOLD;
      else if (stall_ex)     act = ACT_BUBBLE;
      else                   act = ACT_ADVANCE;
      return act;
   endfunction

endpackage

// File: rtl/ex_mem_pipe_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (inc && (count_reg != {W{1'b1}})) begin
         count_reg <= count_reg + W'(1);
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with flush, stall hold, bubble insertion and
// save-back of the execute stage's multi-cycle accumulate state.
module ex_mem_pipe
   import ex_mem_pipe_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int ALUOP_W    = DEF_ALUOP_W,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int PERF_W     = DEF_PERF_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  stall_ex,
   input  logic                  stall_mem,
   input  logic [REG_ADDR_W-1:0] ex_wd,
   input  logic                  ex_wreg,
   input  logic [DATA_W-1:0]     ex_wdata,
   input  logic                  ex_whilo,
   input  logic [DATA_W-1:0]     ex_hi,
   input  logic [DATA_W-1:0]     ex_lo,
   input  logic [ALUOP_W-1:0]    ex_aluop,
   input  logic [DATA_W-1:0]     ex_mem_addr,
   input  logic [DATA_W-1:0]     ex_reg2,
   input  logic [2*DATA_W-1:0]   hilo_i,
   input  logic [CNT_W-1:0]      cnt_i,
   output logic [REG_ADDR_W-1:0] mem_wd,
   output logic                  mem_wreg,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic                  mem_whilo,
   output logic [DATA_W-1:0]     mem_hi,
   output logic [DATA_W-1:0]     mem_lo,
   output logic [ALUOP_W-1:0]    mem_aluop,
   output logic [DATA_W-1:0]     mem_mem_addr,
   output logic [DATA_W-1:0]     mem_reg2,
   output logic                  mem_valid,
   output logic [2*DATA_W-1:0]   hilo_o,
   output logic [CNT_W-1:0]      cnt_o,
   output logic [PERF_W-1:0]     bubble_cnt
);

   localparam logic [REG_ADDR_W-1:0] BUB_WD    = REG_ADDR_W'(NOPRegAddr);
   localparam logic [ALUOP_W-1:0]    BUB_ALUOP = ALUOP_W'(EXE_NOP_OP);
   localparam logic [DATA_W-1:0]     BUB_WORD  = DATA_W'(ZeroWord);

   pipe_act_e act;

   logic [REG_ADDR_W-1:0] wd_reg;
   logic                  wreg_reg;
   logic [DATA_W-1:0]     wdata_reg;
   logic                  whilo_reg;
   logic [DATA_W-1:0]     hi_reg;
   logic [DATA_W-1:0]     lo_reg;
   logic [ALUOP_W-1:0]    aluop_reg;
   logic [DATA_W-1:0]     mem_addr_reg;
   logic [DATA_W-1:0]     reg2_reg;
   logic                  valid_reg;
   logic [2*DATA_W-1:0]   hilo_reg;
   logic [CNT_W-1:0]      cnt_reg;

   always_comb begin
      act = decode_act(rst, flush, stall_mem, stall_ex);
   end

   always_ff @(posedge clk) begin
      case (act)
         ACT_RESET, ACT_FLUSH, ACT_BUBBLE: begin
            wd_reg       <= BUB_WD;
            wreg_reg     <= WriteDisable;
            wdata_reg    <= BUB_WORD;
            whilo_reg    <= WriteDisable;
            hi_reg       <= BUB_WORD;
            lo_reg       <= BUB_WORD;
            aluop_reg    <= BUB_ALUOP;
            mem_addr_reg <= BUB_WORD;
            reg2_reg     <= BUB_WORD;
            valid_reg    <= 1'b0;
            // Only an EX stall preserves the in-flight partial result.
            if (act == ACT_BUBBLE) begin
               hilo_reg <= hilo_i;
               cnt_reg  <= cnt_i;
            end else begin
               hilo_reg <= '0;
               cnt_reg  <= '0;
            end
         end
         ACT_ADVANCE: begin
            wd_reg       <= ex_wd;
            wreg_reg     <= ex_wreg;
            wdata_reg    <= ex_wdata;
            whilo_reg    <= ex_whilo;
            hi_reg       <= ex_hi;
            lo_reg       <= ex_lo;
            aluop_reg    <= ex_aluop;
            mem_addr_reg <= ex_mem_addr;
            reg2_reg     <= ex_reg2;
            valid_reg    <= 1'b1;
            hilo_reg     <= '0;
            cnt_reg      <= '0;
         end
         default: begin
            // ACT_HOLD: every register keeps its value.
         end
      endcase
   end

   sat_counter #(
      .W(PERF_W)
   ) u_bubble_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (act == ACT_BUBBLE),
      .count (bubble_cnt)
   );

   assign mem_wd       = wd_reg;
   assign mem_wreg     = wreg_reg;
   assign mem_wdata    = wdata_reg;
   assign mem_whilo    = whilo_reg;
   assign mem_hi       = hi_reg;
   assign mem_lo       = lo_reg;
   assign mem_aluop    = aluop_reg;
   assign mem_mem_addr = mem_addr_reg;
   assign mem_reg2     = reg2_reg;
   assign mem_valid    = valid_reg;
   assign hilo_o       = hilo_reg;
   assign cnt_o        = cnt_reg;

`ifndef SYNTHESIS
   // A MEM stall must always be accompanied by an EX stall.
   illegal_stall_mem: assert property (@(posedge clk) disable iff (rst)
      !(stall_mem && !stall_ex));
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe, built with a 2-bit bubble counter so that
// saturation is reachable in a handful of cycles.
module tb_ex_mem_pipe;

   localparam int DATA_W = 32;
   localparam int RA_W   = 5;
   localparam int OP_W   = 8;
   localparam int CNT_W  = 2;
   localparam int PERF_W = 2;

   logic              clk = 1'b0;
   logic              rst, flush, stall_ex, stall_mem;
   logic [RA_W-1:0]   ex_wd;
   logic              ex_wreg, ex_whilo;
   logic [DATA_W-1:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
   logic [OP_W-1:0]   ex_aluop;
   logic [63:0]       hilo_i;
   logic [CNT_W-1:0]  cnt_i;
   logic [RA_W-1:0]   mem_wd;
   logic              mem_wreg, mem_whilo, mem_valid;
   logic [DATA_W-1:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
   logic [OP_W-1:0]   mem_aluop;
   logic [63:0]       hilo_o;
   logic [CNT_W-1:0]  cnt_o;
   logic [PERF_W-1:0] bubble_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ex_mem_pipe #(
      .DATA_W(DATA_W), .REG_ADDR_W(RA_W), .ALUOP_W(OP_W),
      .CNT_W(CNT_W), .PERF_W(PERF_W)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush), .stall_ex(stall_ex), .stall_mem(stall_mem),
      .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
      .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr),
      .ex_reg2(ex_reg2), .hilo_i(hilo_i), .cnt_i(cnt_i),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
      .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr),
      .mem_reg2(mem_reg2), .mem_valid(mem_valid), .hilo_o(hilo_o), .cnt_o(cnt_o),
      .bubble_cnt(bubble_cnt)
   );

   task automatic tick(input string tag);
      @(posedge clk);
      #1;
      $display("txn %-12s rst=%0b fl=%0b sx=%0b sm=%0b | wd=%0d wreg=%0b wdata=%h op=%h addr=%h v=%0b cnt=%0d hilo=%h bub=%0d",
               tag, rst, flush, stall_ex, stall_mem, mem_wd, mem_wreg, mem_wdata,
               mem_aluop, mem_mem_addr, mem_valid, cnt_o, hilo_o, bubble_cnt);
   endtask

   task automatic randomize_ex();
      ex_wd       = RA_W'($urandom);
      ex_wreg     = 1'($urandom);
      ex_wdata    = $urandom;
      ex_whilo    = 1'($urandom);
      ex_hi       = $urandom;
      ex_lo       = $urandom;
      ex_aluop    = OP_W'($urandom);
      ex_mem_addr = $urandom;
      ex_reg2     = $urandom;
      hilo_i      = {$urandom, $urandom};
      cnt_i       = CNT_W'($urandom);
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; stall_ex = 1'b0; stall_mem = 1'b0;
      for (int i = 0; i < 2; i++) begin
         randomize_ex();
         tick("reset");
      end
      checks++;
      if ({mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_aluop,
           mem_mem_addr, mem_reg2} !== '0) begin
         errors++;
         $display("FAIL reset_mem_fields: got wd=%0d wreg=%0b wdata=%h op=%h want all zero",
                  mem_wd, mem_wreg, mem_wdata, mem_aluop);
      end
      checks++;
      if (mem_valid !== 1'b0 || cnt_o !== 2'd0 || hilo_o !== 64'd0 || bubble_cnt !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: got v=%0b cnt=%0d hilo=%h bub=%0d want 0 0 0 0",
                  mem_valid, cnt_o, hilo_o, bubble_cnt);
      end
      rst = 1'b0;
   endtask

   task automatic test_advance();
      ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'hDEADBEEF; ex_whilo = 1'b1;
      ex_hi = 32'h1111_2222; ex_lo = 32'h3333_4444; ex_aluop = 8'h21;
      ex_mem_addr = 32'h0000_0040; ex_reg2 = 32'hCAFE_F00D;
      hilo_i = 64'h1234_5678_9ABC_DEF0; cnt_i = 2'd3;
      tick("advance");
      checks++;
      if (mem_wd !== 5'd5 || mem_wreg !== 1'b1 || mem_wdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL advance_wb: got wd=%0d wreg=%0b wdata=%h want 5 1 deadbeef",
                  mem_wd, mem_wreg, mem_wdata);
      end
      checks++;
      if (mem_whilo !== 1'b1 || mem_hi !== 32'h1111_2222 || mem_lo !== 32'h3333_4444 ||
          mem_aluop !== 8'h21 || mem_mem_addr !== 32'h40 || mem_reg2 !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL advance_other: got whilo=%0b hi=%h lo=%h op=%h addr=%h reg2=%h",
                  mem_whilo, mem_hi, mem_lo, mem_aluop, mem_mem_addr, mem_reg2);
      end
      checks++;
      if (mem_valid !== 1'b1 || cnt_o !== 2'd0 || hilo_o !== 64'd0) begin
         errors++;
         $display("FAIL advance_ctl: got v=%0b cnt=%0d hilo=%h want 1 0 0",
                  mem_valid, cnt_o, hilo_o);
      end
   endtask

   task automatic test_back_to_back();
      ex_wd = 5'd9; ex_wreg = 1'b0; ex_wdata = 32'h0000_0009; ex_aluop = 8'h25;
      tick("b2b_1");
      ex_wd = 5'd31; ex_wreg = 1'b1; ex_wdata = 32'hFFFF_0000; ex_aluop = 8'h26;
      checks++;
      if (mem_wd !== 5'd9 || mem_wreg !== 1'b0 || mem_wdata !== 32'h9 || mem_aluop !== 8'h25) begin
         errors++;
         $display("FAIL b2b_first: got wd=%0d wreg=%0b wdata=%h op=%h want 9 0 9 25",
                  mem_wd, mem_wreg, mem_wdata, mem_aluop);
      end
      tick("b2b_2");
      checks++;
      if (mem_wd !== 5'd31 || mem_wreg !== 1'b1 || mem_wdata !== 32'hFFFF_0000 ||
          mem_aluop !== 8'h26 || mem_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second: got wd=%0d wreg=%0b wdata=%h op=%h v=%0b want 31 1 ffff0000 26 1",
                  mem_wd, mem_wreg, mem_wdata, mem_aluop, mem_valid);
      end
   endtask

   task automatic test_ex_stall();
      stall_ex = 1'b1; hilo_i = 64'h0000_0001_0000_0002; cnt_i = 2'd1;
      tick("ex_stall");
      checks++;
      if (mem_valid !== 1'b0 || mem_wreg !== 1'b0 || mem_wd !== 5'd0 || mem_aluop !== 8'h0) begin
         errors++;
         $display("FAIL ex_stall_bubble: got v=%0b wreg=%0b wd=%0d op=%h want 0 0 0 0",
                  mem_valid, mem_wreg, mem_wd, mem_aluop);
      end
      checks++;
      if (cnt_o !== 2'd1 || hilo_o !== 64'h0000_0001_0000_0002 || bubble_cnt !== 2'd1) begin
         errors++;
         $display("FAIL ex_stall_save: got cnt=%0d hilo=%h bub=%0d want 1 0000000100000002 1",
                  cnt_o, hilo_o, bubble_cnt);
      end
      stall_ex = 1'b0; ex_wd = 5'd3; ex_wreg = 1'b1;
      tick("ex_release");
      checks++;
      if (cnt_o !== 2'd0 || hilo_o !== 64'd0 || mem_valid !== 1'b1 || mem_wd !== 5'd3 ||
          bubble_cnt !== 2'd1) begin
         errors++;
         $display("FAIL ex_release: got cnt=%0d hilo=%h v=%0b wd=%0d bub=%0d want 0 0 1 3 1",
                  cnt_o, hilo_o, mem_valid, mem_wd, bubble_cnt);
      end
   endtask

   task automatic test_mem_stall();
      ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'h0; ex_aluop = 8'hA3;
      ex_mem_addr = 32'h0000_1000; ex_reg2 = 32'h0;
      tick("load");
      stall_ex = 1'b1; stall_mem = 1'b1;
      for (int i = 0; i < 3; i++) begin
         randomize_ex();
         tick("mem_stall");
         checks++;
         if (mem_wd !== 5'd7 || mem_wreg !== 1'b1 || mem_aluop !== 8'hA3 ||
             mem_mem_addr !== 32'h1000 || mem_valid !== 1'b1) begin
            errors++;
            $display("FAIL mem_stall_hold[%0d]: got wd=%0d wreg=%0b op=%h addr=%h v=%0b want 7 1 a3 1000 1",
                     i, mem_wd, mem_wreg, mem_aluop, mem_mem_addr, mem_valid);
         end
         checks++;
         if (bubble_cnt !== 2'd1 || cnt_o !== 2'd0 || hilo_o !== 64'd0) begin
            errors++;
            $display("FAIL mem_stall_state[%0d]: got bub=%0d cnt=%0d hilo=%h want 1 0 0",
                     i, bubble_cnt, cnt_o, hilo_o);
         end
      end
   endtask

   task automatic test_flush();
      // Continues from the MEM stall: a valid load is still in MEM.
      flush = 1'b1;
      tick("flush_sm");
      checks++;
      if (mem_valid !== 1'b0 || mem_wd !== 5'd0 || mem_wreg !== 1'b0 || cnt_o !== 2'd0 ||
          mem_aluop !== 8'h0 || bubble_cnt !== 2'd1) begin
         errors++;
         $display("FAIL flush_priority: got v=%0b wd=%0d wreg=%0b cnt=%0d op=%h bub=%0d want 0 0 0 0 0 1",
                  mem_valid, mem_wd, mem_wreg, cnt_o, mem_aluop, bubble_cnt);
      end
      flush = 1'b0; stall_mem = 1'b0; stall_ex = 1'b1;
      hilo_i = 64'hAAAA_BBBB_CCCC_DDDD; cnt_i = 2'd3;
      tick("ex_stall2");
      flush = 1'b1;
      tick("flush_sx");
      checks++;
      if (cnt_o !== 2'd0 || hilo_o !== 64'd0 || bubble_cnt !== 2'd2 || mem_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_clears_hilo: got cnt=%0d hilo=%h bub=%0d v=%0b want 0 0 2 0",
                  cnt_o, hilo_o, bubble_cnt, mem_valid);
      end
      flush = 1'b0; stall_ex = 1'b0;
   endtask

   task automatic test_reset_mid_stall();
      stall_ex = 1'b1; cnt_i = 2'd2; hilo_i = 64'h55;
      tick("pre_rst");
      rst = 1'b1;
      tick("rst_stall");
      checks++;
      if (cnt_o !== 2'd0 || hilo_o !== 64'd0 || bubble_cnt !== 2'd0 || mem_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_stall: got cnt=%0d hilo=%h bub=%0d v=%0b want 0 0 0 0",
                  cnt_o, hilo_o, bubble_cnt, mem_valid);
      end
      rst = 1'b0; stall_ex = 1'b0; ex_wd = 5'd12; ex_wreg = 1'b1; ex_wdata = 32'h1234_5678;
      tick("post_rst");
      checks++;
      if (mem_valid !== 1'b1 || mem_wd !== 5'd12 || mem_wdata !== 32'h1234_5678 || cnt_o !== 2'd0) begin
         errors++;
         $display("FAIL post_rst_advance: got v=%0b wd=%0d wdata=%h cnt=%0d want 1 12 12345678 0",
                  mem_valid, mem_wd, mem_wdata, cnt_o);
      end
   endtask

   task automatic test_saturation();
      logic [PERF_W-1:0] exp_seq [5];
      exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      rst = 1'b1;
      tick("sat_rst");
      rst = 1'b0; stall_ex = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cnt_i = CNT_W'(i);
         tick("sat");
         checks++;
         if (bubble_cnt !== exp_seq[i]) begin
            errors++;
            $display("FAIL saturation[%0d]: got bub=%0d want %0d", i, bubble_cnt, exp_seq[i]);
         end
      end
      stall_ex = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; stall_ex = 1'b0; stall_mem = 1'b0;
      randomize_ex();
      test_reset();
      test_advance();
      test_back_to_back();
      test_ex_stall();
      test_mem_stall();
      test_flush();
      test_reset_mid_stall();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
